video_line_buffer: RTL and testbench

- Double-buffered scanline store between the layer renderer and the palette lookup that feeds the VGA output stage.
- The renderer fills the back bank with 8-bit palette indices for the next line.
- The display side reads the front bank, driven by the timing strobes `next_line`, `next_pixel` and `next_frame`, with horizontal scaling and border fill.
- One output register stage plus the palette RAM's one read cycle equals the output stage's 2-cycle active-delay compensation.

---
 rtl/video_line_buffer.sv | 102 ++++++++++
 tb/tb_video_line_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_buffer.sv
// Double-buffered scanline store: renderer fills the back bank, display reads the front bank with scaling and border.
// Latency: palette_idx is valid 1 clock after its address cycle; no backpressure, strobes advance unconditionally.
module video_line_buffer #(
    parameter int LINE_PIXELS = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_frame,
    input  logic       next_line,
    input  logic       next_pixel,
    input  logic [7:0] hscale,
    input  logic [7:0] border_color,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       render_start,
    output logic [9:0] render_line,
    output logic       buf_sel,
    output logic [7:0] palette_idx
);

    localparam logic [10:0] LINE_PIXELS_W = 11'(LINE_PIXELS);
    localparam logic [16:0] XACC_MAX      = 17'h1FFFF;
    localparam logic [9:0]  LINE_MAX      = 10'd1023;

    logic [7:0]  bank0_mem [1024];
    logic [7:0]  bank1_mem [1024];

    logic        buf_sel_q, buf_sel_d;
    logic [16:0] xacc_q, xacc_d;
    logic [7:0]  pix_q, pix_d;
    logic        rs_q, rs_d;
    logic [9:0]  rl_q, rl_d;

    logic [9:0]  rd_addr;
    logic        rd_border;
    logic [7:0]  bank0_rd;
    logic [7:0]  bank1_rd;
    logic [17:0] xacc_sum;
    logic        wr_ok;

    assign rd_addr   = xacc_q[16:7];
    assign rd_border = ({1'b0, rd_addr} >= LINE_PIXELS_W);
    assign bank0_rd  = bank0_mem[rd_addr];
    assign bank1_rd  = bank1_mem[rd_addr];
    assign xacc_sum  = {1'b0, xacc_q} + {10'd0, hscale};
    assign wr_ok     = wr_en && !rst && ({1'b0, wr_addr} < LINE_PIXELS_W);

    // Writes target the back bank as seen before any swap in this cycle.
    always_ff @(posedge clk) begin
        if (wr_ok && buf_sel_q) begin
            bank0_mem[wr_addr] <= wr_data;
        end
        if (wr_ok && !buf_sel_q) begin
            bank1_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        buf_sel_d = buf_sel_q;
        xacc_d    = xacc_q;
        rs_d      = 1'b0;
        rl_d      = rl_q;
        pix_d     = rd_border ? border_color : (buf_sel_q ? bank1_rd : bank0_rd);

        if (next_line) begin
            buf_sel_d = ~buf_sel_q;
            xacc_d    = '0;
            // Back-to-back next_line still yields isolated one-cycle pulses.
            rs_d      = ~rs_q;
            if (next_frame) begin
                rl_d = '0;
            end else if (rl_q != LINE_MAX) begin
                rl_d = rl_q + 10'd1;
            end
        end else if (next_pixel) begin
            xacc_d = xacc_sum[17] ? XACC_MAX : xacc_sum[16:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_sel_q <= 1'b0;
            xacc_q    <= '0;
            pix_q     <= '0;
            rs_q      <= 1'b0;
            rl_q      <= '0;
        end else begin
            buf_sel_q <= buf_sel_d;
            xacc_q    <= xacc_d;
            pix_q     <= pix_d;
            rs_q      <= rs_d;
            rl_q      <= rl_d;
        end
    end

    assign buf_sel      = buf_sel_q;
    assign palette_idx  = pix_q;
    assign render_start = rs_q;
    assign render_line  = rl_q;

endmodule

// File: tb/tb_video_line_buffer.sv
// Directed bench for video_line_buffer: reset, 1:1 and scaled reads, border, line counter, swap-cycle write, mid-line reset.
module tb_video_line_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       next_frame;
    logic       next_line;
    logic       next_pixel;
    logic [7:0] hscale;
    logic [7:0] border_color;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       render_start;
    logic [9:0] render_line;
    logic       buf_sel;
    logic [7:0] palette_idx;

    int         checks = 0;
    int         errors = 0;
    logic       exp_sel;
    logic       exp_rs;
    logic [7:0] key_of [2];
    logic [7:0] exp_pix;
    int         addr;

    video_line_buffer #(.LINE_PIXELS(640)) dut (
        .clk          (clk),
        .rst          (rst),
        .next_frame   (next_frame),
        .next_line    (next_line),
        .next_pixel   (next_pixel),
        .hscale       (hscale),
        .border_color (border_color),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .render_start (render_start),
        .render_line  (render_line),
        .buf_sel      (buf_sel),
        .palette_idx  (palette_idx)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fill the back bank with addr[7:0]^key over all valid addresses.
    task automatic fill_back(input logic [7:0] key);
        for (int a = 0; a < 640; a++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(a);
            wr_data = 8'(a) ^ key;
            step();
        end
        wr_en = 1'b0;
        key_of[~exp_sel] = key;
    endtask

    initial begin
        rst          = 1'b1;
        next_frame   = 1'b0;
        next_line    = 1'b0;
        next_pixel   = 1'b0;
        hscale       = 8'd128;
        border_color = 8'hE3;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        exp_sel      = 1'b0;
        key_of[0]    = 8'h00;
        key_of[1]    = 8'h00;

        // Reset held 2 cycles with random inputs toggling.
        for (int i = 0; i < 2; i++) begin
            next_frame = 1'($urandom);
            next_line  = 1'($urandom);
            next_pixel = 1'($urandom);
            hscale     = 8'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = 10'($urandom);
            wr_data    = 8'($urandom);
            step();
        end
        rst        = 1'b0;
        next_frame = 1'b0;
        next_line  = 1'b0;
        next_pixel = 1'b0;
        wr_en      = 1'b0;
        hscale     = 8'd128;
        check("reset_palette_idx", 32'(palette_idx), 32'h0);
        check("reset_buf_sel", 32'(buf_sel), 32'h0);
        check("reset_render_line", 32'(render_line), 32'h0);
        check("reset_render_start", 32'(render_start), 32'h0);

        // 1:1 read of pattern 0x5A.
        fill_back(8'h5A);
        next_line = 1'b1;
        step();
        next_line = 1'b0;
        exp_sel   = ~exp_sel;
        check("swap_buf_sel", 32'(buf_sel), 32'(exp_sel));
        check("swap_render_start", 32'(render_start), 32'h1);
        check("swap_render_line", 32'(render_line), 32'd1);
        next_pixel = 1'b1;
        for (int x = 0; x < 640; x++) begin
            step();
            check($sformatf("scale1_x%0d", x), 32'(palette_idx), 32'(8'(x) ^ key_of[exp_sel]));
            if (x == 0) check("render_start_one_cycle", 32'(render_start), 32'h0);
        end
        next_pixel = 1'b0;

        // 2x zoom of pattern 0x3C.
        fill_back(8'h3C);
        hscale    = 8'd64;
        next_line = 1'b1;
        step();
        next_line  = 1'b0;
        exp_sel    = ~exp_sel;
        next_pixel = 1'b1;
        for (int x = 0; x < 640; x++) begin
            step();
            check($sformatf("scale64_x%0d", x), 32'(palette_idx), 32'(8'(x / 2) ^ key_of[exp_sel]));
        end
        next_pixel = 1'b0;

        // hscale=255 reaches the border and then saturates.
        hscale    = 8'd255;
        next_line = 1'b1;
        step();
        next_line  = 1'b0;
        exp_sel    = ~exp_sel;
        next_pixel = 1'b1;
        for (int x = 0; x < 640; x++) begin
            step();
            addr    = (x * 255) / 128;
            exp_pix = (addr >= 640) ? 8'hE3 : (8'(addr) ^ key_of[exp_sel]);
            check($sformatf("scale255_x%0d", x), 32'(palette_idx), 32'(exp_pix));
        end
        next_pixel = 1'b0;

        // Held pixel: address and output stay put.
        hscale    = 8'd128;
        next_line = 1'b1;
        step();
        next_line  = 1'b0;
        exp_sel    = ~exp_sel;
        next_pixel = 1'b1;
        step();
        step();
        next_pixel = 1'b0;
        step();
        step();
        check("hold_pixel", 32'(palette_idx), 32'(8'd2 ^ key_of[exp_sel]));

        // Line counter: frame restart, increments, ignored lone next_frame.
        next_line  = 1'b1;
        next_frame = 1'b1;
        step();
        next_line  = 1'b0;
        next_frame = 1'b0;
        exp_sel    = ~exp_sel;
        check("frame_render_line", 32'(render_line), 32'd0);
        check("frame_render_start", 32'(render_start), 32'h1);
        step();
        for (int k = 1; k <= 5; k++) begin
            next_line = 1'b1;
            step();
            next_line = 1'b0;
            exp_sel   = ~exp_sel;
            check($sformatf("line_%0d_render_line", k), 32'(render_line), 32'(k));
            check($sformatf("line_%0d_render_start", k), 32'(render_start), 32'h1);
            check($sformatf("line_%0d_buf_sel", k), 32'(buf_sel), 32'(exp_sel));
            step();
            check($sformatf("line_%0d_start_drop", k), 32'(render_start), 32'h0);
        end
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        check("lone_frame_line", 32'(render_line), 32'd5);
        check("lone_frame_start", 32'(render_start), 32'h0);
        next_line  = 1'b1;
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        exp_sel    = ~exp_sel;
        check("frame2_render_line", 32'(render_line), 32'd0);
        // next_line stays high: 1030 back-to-back lines.
        exp_rs = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            step();
            exp_sel = ~exp_sel;
            exp_rs  = ~exp_rs;
            check($sformatf("b2b_start_%0d", i), 32'(render_start), 32'(exp_rs));
        end
        next_line = 1'b0;
        check("saturate_render_line", 32'(render_line), 32'd1023);
        check("b2b_buf_sel", 32'(buf_sel), 32'(exp_sel));
        step();

        // Swap-cycle write lands in the new front bank.
        hscale    = 8'd128;
        next_line = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 10'd7;
        wr_data   = 8'hC4;
        step();
        next_line  = 1'b0;
        wr_en      = 1'b0;
        exp_sel    = ~exp_sel;
        next_pixel = 1'b1;
        for (int x = 0; x < 300; x++) begin
            step();
            exp_pix = (x == 7) ? 8'hC4 : (8'(x) ^ key_of[exp_sel]);
            check($sformatf("swapwr_x%0d", x), 32'(palette_idx), 32'(exp_pix));
        end

        // One-cycle reset at x=300.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_sel = 1'b0;
        check("midreset_palette_idx", 32'(palette_idx), 32'h0);
        check("midreset_buf_sel", 32'(buf_sel), 32'h0);
        check("midreset_render_line", 32'(render_line), 32'h0);
        check("midreset_render_start", 32'(render_start), 32'h0);
        step();
        check("midreset_x0", 32'(palette_idx), 32'(8'd0 ^ key_of[0]));
        step();
        check("midreset_x1", 32'(palette_idx), 32'(8'd1 ^ key_of[0]));
        next_pixel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
